// File: rtl/ifm_pkg.sv
// Shared codes and types for the IFM window-buffer sequencer: move/mode encodings,
// FSM states, and the mapping from a fetch index to its destination byte slot.
package ifm_pkg;

   localparam logic [1:0] MODE_OFF    = 2'b00;
   localparam logic [1:0] MODE_CONVOL = 2'b01;
   localparam logic [1:0] MODE_FULLY  = 2'b10;
   localparam logic [1:0] MODE_POOL   = 2'b11;

   typedef enum logic [2:0] {
      MV_RIGHT = 3'b001,
      MV_DOWN  = 3'b010,
      MV_LEFT  = 3'b100,
      MV_NONE  = 3'b101,
      MV_ALL   = 3'b111
   } move_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   // word selects ifm_input[word]; lane 0 is the most significant pixel byte
   typedef struct packed {
      logic [1:0] word;
      logic [1:0] lane;
   } slot_t;

   function automatic slot_t slot_of(input move_t mv, input logic [3:0] idx);
      slot_t s;
      s = '{2'd0, idx[1:0]};
      case (mv)
         MV_ALL: begin
            case (idx)
               4'd0:    s = '{2'd0, 2'd0};
               4'd1:    s = '{2'd0, 2'd1};
               4'd2:    s = '{2'd0, 2'd2};
               4'd3:    s = '{2'd1, 2'd0};
               4'd4:    s = '{2'd1, 2'd1};
               4'd5:    s = '{2'd1, 2'd2};
               4'd6:    s = '{2'd2, 2'd0};
               4'd7:    s = '{2'd2, 2'd1};
               default: s = '{2'd2, 2'd2};
            endcase
         end
         MV_DOWN: s = '{2'd1, idx[1:0]};
         MV_LEFT: s = '{2'd2, idx[1:0]};
         default: s = '{2'd0, idx[1:0]};
      endcase
      return s;
   endfunction

endpackage

// File: rtl/ifm_fetch_unit.sv
// Issues the back-to-back SRAM reads for one window move and packs the returned
// pixels into the three 24-bit-wide buffer words, one cycle behind the reads.
module ifm_fetch_unit
   import ifm_pkg::*;
#(
   parameter int IMG_W  = 8,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  move_t             go_move,
   input  logic [7:0]        go_row,
   input  logic [7:0]        go_col,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [2:0][31:0]  ifm_input,
   output logic              last_cap
);

   move_t       mv;
   logic [7:0]  base_col;
   logic [7:0]  rd_row, rd_col;
   logic [3:0]  rd_cnt;
   logic        cap_en;
   logic [3:0]  cap_cnt;
   logic [3:0]  last_idx;
   logic [7:0]  nxt_row, nxt_col;
   logic [3:0]  nxt_cnt;
   logic        nxt_en;
   logic [ADDR_W-1:0] nxt_addr;
   slot_t       cap_slot;

   assign last_idx = (mv == MV_ALL) ? 4'd8 : 4'd2;
   assign last_cap = cap_en && (cap_cnt == last_idx);
   assign cap_slot = slot_of(mv, cap_cnt);
   assign nxt_addr = ADDR_W'(32'(nxt_row) * IMG_W + 32'(nxt_col));

   // rd_row/rd_col track the pixel being read; ALL walks row-major inside the window
   always_comb begin
      nxt_row = rd_row;
      nxt_col = rd_col;
      nxt_cnt = rd_cnt;
      nxt_en  = mem_rd_en;
      if (go) begin
         nxt_en  = 1'b1;
         nxt_cnt = 4'd0;
         nxt_row = go_row;
         nxt_col = go_col;
         case (go_move)
            MV_RIGHT: nxt_col = go_col + 8'd3;
            MV_DOWN:  nxt_row = go_row + 8'd3;
            MV_LEFT:  nxt_col = go_col - 8'd1;
            default:  ;
         endcase
      end else if (mem_rd_en) begin
         if (rd_cnt == last_idx) begin
            nxt_en = 1'b0;
         end else begin
            nxt_cnt = rd_cnt + 4'd1;
            case (mv)
               MV_ALL: begin
                  if (rd_col == base_col + 8'd2) begin
                     nxt_col = base_col;
                     nxt_row = rd_row + 8'd1;
                  end else begin
                     nxt_col = rd_col + 8'd1;
                  end
               end
               MV_DOWN: nxt_col = rd_col + 8'd1;
               default: nxt_row = rd_row + 8'd1;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mv        <= MV_NONE;
         base_col  <= 8'd0;
         rd_row    <= 8'd0;
         rd_col    <= 8'd0;
         rd_cnt    <= 4'd0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         cap_en    <= 1'b0;
         cap_cnt   <= 4'd0;
         ifm_input <= '0;
      end else begin
         if (go) begin
            mv       <= go_move;
            base_col <= go_col;
         end
         rd_row    <= nxt_row;
         rd_col    <= nxt_col;
         rd_cnt    <= nxt_cnt;
         mem_rd_en <= nxt_en;
         mem_addr  <= nxt_addr;
         // data returns one cycle after its strobe, so capture trails the read counter
         cap_en    <= mem_rd_en;
         cap_cnt   <= rd_cnt;
         if (cap_en) begin
            case (cap_slot.lane)
               2'd0:    ifm_input[cap_slot.word][23:16] <= mem_rdata;
               2'd1:    ifm_input[cap_slot.word][15:8]  <= mem_rdata;
               default: ifm_input[cap_slot.word][7:0]   <= mem_rdata;
            endcase
         end
      end
   end

endmodule

// File: rtl/ifm_scan_ctrl.sv
// Serpentine 3x3 window scan over the feature map: owns the FSM, window position and
// band direction, and hands each move to the fetch unit before issuing the command.
module ifm_scan_ctrl
   import ifm_pkg::*;
#(
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   output logic [1:0]        ifm_mode,
   output logic [2:0]        ifm_read,
   output logic [2:0][31:0]  ifm_input,
   output logic              win_valid,
   input  logic              pe_ready,
   output logic [7:0]        win_row,
   output logic [7:0]        win_col,
   output logic              busy,
   output logic              done
);

   generate
      if (IMG_W < 3 || IMG_H < 3) begin : g_size_check
         $error("ifm_scan_ctrl: IMG_W and IMG_H must both be at least 3");
      end
   endgenerate

   localparam logic [7:0] COL_END = 8'(IMG_W - 3);
   localparam logic [7:0] ROW_END = 8'(IMG_H - 3);

   state_t     state, state_nxt;
   move_t      cur_move, go_move, step_move;
   logic       dir;
   logic       go, last_cap, band_end, last_win;
   logic [7:0] go_row, go_col;

   always_comb begin
      band_end  = dir ? (win_col == 8'd0) : (win_col == COL_END);
      last_win  = band_end && (win_row == ROW_END);
      step_move = band_end ? MV_DOWN : (dir ? MV_LEFT : MV_RIGHT);
      state_nxt = state;
      go        = 1'b0;
      go_move   = MV_ALL;
      go_row    = 8'd0;
      go_col    = 8'd0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = ST_FETCH;
               go        = 1'b1;
            end
         end
         ST_FETCH: if (last_cap) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (pe_ready) begin
               if (last_win) begin
                  state_nxt = ST_DONE;
               end else begin
                  state_nxt = ST_FETCH;
                  go        = 1'b1;
                  go_move   = step_move;
                  go_row    = win_row;
                  go_col    = win_col;
               end
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         cur_move <= MV_ALL;
         dir      <= 1'b0;
         win_row  <= 8'd0;
         win_col  <= 8'd0;
      end else begin
         state <= state_nxt;
         if (go) cur_move <= go_move;
         // the position moves only once the new pixels are in the buffer
         if (state == ST_FETCH && last_cap) begin
            case (cur_move)
               MV_ALL: begin
                  win_row <= 8'd0;
                  win_col <= 8'd0;
                  dir     <= 1'b0;
               end
               MV_RIGHT: win_col <= win_col + 8'd1;
               MV_LEFT:  win_col <= win_col - 8'd1;
               MV_DOWN: begin
                  win_row <= win_row + 8'd1;
                  dir     <= ~dir;
               end
               default: ;
            endcase
         end
      end
   end

   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign win_valid = (state == ST_WAIT);
   assign ifm_read  = (state == ST_ISSUE) ? cur_move : MV_NONE;
   assign ifm_mode  = busy ? MODE_CONVOL : MODE_OFF;

   ifm_fetch_unit #(
      .IMG_W (IMG_W),
      .ADDR_W(ADDR_W)
   ) u_fetch (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .go_move  (go_move),
      .go_row   (go_row),
      .go_col   (go_col),
      .mem_rd_en(mem_rd_en),
      .mem_addr (mem_addr),
      .mem_rdata(mem_rdata),
      .ifm_input(ifm_input),
      .last_cap (last_cap)
   );

endmodule

// File: tb/tb_ifm_scan_ctrl.sv
// Bench for ifm_scan_ctrl: three instances (4x4, 3x3, 3x5) with a mem[a]=a[7:0] SRAM model
// and a window-sequence scoreboard popped on every issued command.
module tb_ifm_scan_ctrl;

   localparam logic [2:0] C_ALL   = 3'b111;
   localparam logic [2:0] C_RIGHT = 3'b001;
   localparam logic [2:0] C_DOWN  = 3'b010;
   localparam logic [2:0] C_LEFT  = 3'b100;
   localparam logic [2:0] C_NONE  = 3'b101;

   typedef struct {
      logic [2:0]  mv;
      logic [31:0] w0, w1, w2;
      logic [7:0]  r, c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   logic             start_i [3];
   logic             pe_i    [3];
   logic [7:0]       rdata_i [3];
   logic             rd_en_o [3];
   logic [11:0]      addr_o  [3];
   logic [1:0]       mode_o  [3];
   logic [2:0]       read_o  [3];
   logic [2:0][31:0] inp_o   [3];
   logic             vld_o   [3];
   logic [7:0]       row_o   [3];
   logic [7:0]       col_o   [3];
   logic             busy_o  [3];
   logic             done_o  [3];

   exp_t q [3][$];
   int   rd_cnt [3];
   int   cmd_cnt [3];
   int   done_cnt [3];
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++)
         if (rd_en_o[k]) rdata_i[k] <= addr_o[k][7:0];
   end

   ifm_scan_ctrl #(.IMG_W(4), .IMG_H(4), .ADDR_W(12)) u_dut44 (
      .clk(clk), .rst(rst), .start(start_i[0]), .mem_rd_en(rd_en_o[0]), .mem_addr(addr_o[0]),
      .mem_rdata(rdata_i[0]), .ifm_mode(mode_o[0]), .ifm_read(read_o[0]), .ifm_input(inp_o[0]),
      .win_valid(vld_o[0]), .pe_ready(pe_i[0]), .win_row(row_o[0]), .win_col(col_o[0]),
      .busy(busy_o[0]), .done(done_o[0]));

   ifm_scan_ctrl #(.IMG_W(3), .IMG_H(3), .ADDR_W(12)) u_dut33 (
      .clk(clk), .rst(rst), .start(start_i[1]), .mem_rd_en(rd_en_o[1]), .mem_addr(addr_o[1]),
      .mem_rdata(rdata_i[1]), .ifm_mode(mode_o[1]), .ifm_read(read_o[1]), .ifm_input(inp_o[1]),
      .win_valid(vld_o[1]), .pe_ready(pe_i[1]), .win_row(row_o[1]), .win_col(col_o[1]),
      .busy(busy_o[1]), .done(done_o[1]));

   ifm_scan_ctrl #(.IMG_W(3), .IMG_H(5), .ADDR_W(12)) u_dut35 (
      .clk(clk), .rst(rst), .start(start_i[2]), .mem_rd_en(rd_en_o[2]), .mem_addr(addr_o[2]),
      .mem_rdata(rdata_i[2]), .ifm_mode(mode_o[2]), .ifm_read(read_o[2]), .ifm_input(inp_o[2]),
      .win_valid(vld_o[2]), .pe_ready(pe_i[2]), .win_row(row_o[2]), .win_col(col_o[2]),
      .busy(busy_o[2]), .done(done_o[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [7:0] px(input int w, input int r, input int c);
      return 8'((r * w + c) & 255);
   endfunction

   // Reference serpentine walk: one entry per window in issue order
   task automatic build(input int k, input int w, input int h);
      logic [31:0] wd [3];
      int   r, c, nwin;
      bit   dir;
      exp_t e;
      r = 0; c = 0; dir = 1'b0;
      nwin = (h - 2) * (w - 2);
      q[k].delete();
      for (int i = 0; i < 3; i++) wd[i] = {8'h00, px(w, i, 0), px(w, i, 1), px(w, i, 2)};
      e.mv = C_ALL; e.w0 = wd[0]; e.w1 = wd[1]; e.w2 = wd[2]; e.r = 8'd0; e.c = 8'd0;
      q[k].push_back(e);
      for (int n = 1; n < nwin; n++) begin
         if ((dir && c == 0) || (!dir && c == w - 3)) begin
            e.mv  = C_DOWN;
            wd[1] = {8'h00, px(w, r + 3, c), px(w, r + 3, c + 1), px(w, r + 3, c + 2)};
            r++;
            dir = !dir;
         end else if (!dir) begin
            e.mv  = C_RIGHT;
            wd[0] = {8'h00, px(w, r, c + 3), px(w, r + 1, c + 3), px(w, r + 2, c + 3)};
            c++;
         end else begin
            e.mv  = C_LEFT;
            wd[2] = {8'h00, px(w, r, c - 1), px(w, r + 1, c - 1), px(w, r + 2, c - 1)};
            c--;
         end
         e.w0 = wd[0]; e.w1 = wd[1]; e.w2 = wd[2]; e.r = 8'(r); e.c = 8'(c);
         q[k].push_back(e);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            if (rd_en_o[k] === 1'b1) rd_cnt[k]++;
            if (done_o[k] === 1'b1) done_cnt[k]++;
            if (read_o[k] !== C_NONE && !rst) begin
               cmd_cnt[k]++;
               if (q[k].size() == 0) begin
                  chk("extra_cmd", 32'(read_o[k]), 32'(C_NONE));
               end else begin
                  e = q[k].pop_front();
                  chk("cmd_move", 32'(read_o[k]), 32'(e.mv));
                  chk("word0", inp_o[k][0], e.w0);
                  chk("word1", inp_o[k][1], e.w1);
                  chk("word2", inp_o[k][2], e.w2);
                  chk("win_row", 32'(row_o[k]), 32'(e.r));
                  chk("win_col", 32'(col_o[k]), 32'(e.c));
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset(input int k);
      chk("rst_rd_en", 32'(rd_en_o[k]), 0);
      chk("rst_addr", 32'(addr_o[k]), 0);
      chk("rst_mode", 32'(mode_o[k]), 0);
      chk("rst_read", 32'(read_o[k]), 32'(C_NONE));
      chk("rst_input", inp_o[k][0] | inp_o[k][1] | inp_o[k][2], 0);
      chk("rst_valid", 32'(vld_o[k]), 0);
      chk("rst_row", 32'(row_o[k]), 0);
      chk("rst_col", 32'(col_o[k]), 0);
      chk("rst_busy", 32'(busy_o[k]), 0);
      chk("rst_done", 32'(done_o[k]), 0);
   endtask

   // Returns at the falling edge of the cycle carrying a command
   task automatic wait_cmd(input int k, input int budget, output int c);
      c = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (read_o[k] !== C_NONE) begin
            c = cyc;
            return;
         end
      end
      chk("cmd_timeout", 0, 1);
   endtask

   task automatic run_scan(input int k, input int w, input int h, input bit special);
      int s, c, p, nwin, bv, bc, br, bb;
      nwin = (h - 2) * (w - 2);
      build(k, w, h);
      rd_cnt[k] = 0; cmd_cnt[k] = 0; done_cnt[k] = 0;
      start_i[k] = 1'b1;
      s = cyc;
      tick();
      start_i[k] = 1'b0;
      @(negedge clk);
      chk("busy_after_start", 32'(busy_o[k]), 1);
      chk("mode_convol", 32'(mode_o[k]), 1);
      chk("first_rd_en", 32'(rd_en_o[k]), 1);
      chk("first_addr", 32'(addr_o[k]), 0);
      wait_cmd(k, 40, c);
      chk("all_latency", c, s + 11);
      for (int n = 0; n < nwin; n++) begin
         if (special && n == 0) begin
            pe_i[k] = 1'b1;
            tick();
            pe_i[k] = 1'b0;
            bv = 0;
            repeat (3) begin
               @(negedge clk);
               if (vld_o[k] !== 1'b1) bv++;
            end
            chk("pe_during_issue_ignored", bv, 0);
            tick();
            pe_i[k] = 1'b1;
            p = cyc;
            tick();
            pe_i[k] = 1'b0;
         end else if (special && n == 1) begin
            tick();
            bv = 0; bc = 0; br = 0; bb = 0;
            for (int i = 0; i < 20; i++) begin
               start_i[k] = (i == 5 || i == 12);
               @(negedge clk);
               if (vld_o[k] !== 1'b1) bv++;
               if (read_o[k] !== C_NONE) bc++;
               if (rd_en_o[k] !== 1'b0) br++;
               if (busy_o[k] !== 1'b1) bb++;
               tick();
            end
            start_i[k] = 1'b0;
            chk("hold_valid_drops", bv, 0);
            chk("hold_cmd_seen", bc, 0);
            chk("hold_rd_en_seen", br, 0);
            chk("hold_busy_drops", bb, 0);
            pe_i[k] = 1'b1;
            p = cyc;
            tick();
            pe_i[k] = 1'b0;
         end else if (special && n == 2) begin
            pe_i[k] = 1'b1;
            tick();
            p = cyc;
            tick();
            pe_i[k] = 1'b0;
         end else begin
            chk("valid_at_cmd", 32'(vld_o[k]), 0);
            tick();
            pe_i[k] = 1'b1;
            p = cyc;
            @(negedge clk);
            chk("valid_rise", 32'(vld_o[k]), 1);
            tick();
            pe_i[k] = 1'b0;
         end
         if (n < nwin - 1) begin
            wait_cmd(k, 40, c);
            chk("move_latency", c, p + 5);
         end else begin
            @(negedge clk);
            chk("done_pulse", 32'(done_o[k]), 1);
            chk("busy_in_done", 32'(busy_o[k]), 1);
            chk("valid_after_accept", 32'(vld_o[k]), 0);
            if (special) start_i[k] = 1'b1;
            tick();
            start_i[k] = 1'b0;
            @(negedge clk);
            chk("done_one_cycle", 32'(done_o[k]), 0);
            chk("busy_falls", 32'(busy_o[k]), 0);
            tick();
            @(negedge clk);
            chk("start_with_done_ignored", 32'(busy_o[k]), 0);
            tick();
         end
      end
      chk("cmd_count", cmd_cnt[k], nwin);
      chk("done_count", done_cnt[k], 1);
      chk("scoreboard_empty", q[k].size(), 0);
      chk("read_count", rd_cnt[k], 9 + 3 * (nwin - 1));
   endtask

   initial begin
      int s;
      for (int k = 0; k < 3; k++) begin
         start_i[k] = 1'b0;
         pe_i[k] = 1'b0;
         rd_cnt[k] = 0;
         cmd_cnt[k] = 0;
         done_cnt[k] = 0;
      end
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < 3; k++) chk_reset(k);
      tick();

      run_scan(0, 4, 4, 1'b1);

      // abort in the middle of the ALL fetch
      q[0].delete();
      start_i[0] = 1'b1;
      s = cyc;
      tick();
      start_i[0] = 1'b0;
      repeat (3) tick();
      chk("abort_in_fetch", 32'(rd_en_o[0]), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("abort_cycle", cyc, s + 5);
      chk_reset(0);
      tick();

      run_scan(0, 4, 4, 1'b0);
      run_scan(1, 3, 3, 1'b0);
      run_scan(2, 3, 5, 1'b0);

      repeat (4) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
